// File: rtl/seven_seg_scan_display.sv
// 6-digit multiplexed seven-segment driver for the clock's sec/min/hour bus, with blinking edit field.
// Optional: define HOUR_ZERO_BLANK_EN to suppress the leading zero of the hour tens digit.
`ifndef KILO
`define KILO 1000
`endif
`ifndef SELECT_NONE
`define SELECT_NONE 2'd0
`endif
`ifndef SELECT_SEC
`define SELECT_SEC 2'd1
`endif
`ifndef SELECT_MIN
`define SELECT_MIN 2'd2
`endif
`ifndef SELECT_HOUR
`define SELECT_HOUR 2'd3
`endif

module seven_seg_scan_display #(
   parameter int CLK_FREQ_HZ       = `KILO,
   parameter int DIGIT_HOLD_CYCLES = 4,
   parameter int BLINK_HZ          = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] sec_in,
   input  logic [5:0] min_in,
   input  logic [4:0] hour_in,
   input  logic [1:0] select,
   output logic [5:0] an_out,
   output logic [6:0] seg_out,
   output logic       dp_out,
   output logic       frame_out
);
   localparam int BLINK_HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
   localparam int HOLD_W     = $clog2(DIGIT_HOLD_CYCLES);
   localparam int BLINK_W    = $clog2(BLINK_HALF + 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(DIGIT_HOLD_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEC, ST_MIN, ST_HOUR, ST_COMMIT} conv_state_t;

   conv_state_t          state, state_nxt;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [2:0]           digit_idx;
   logic [BLINK_W-1:0]   blink_cnt;
   logic                 blink_vis;
   logic [5:0]           work;
   logic [2:0]           tens;
   logic [5:0]           min_w;
   logic [4:0]           hour_w;
   logic [5:0][3:0]      stage;
   logic [5:0][3:0]      disp;
   logic                 field_done;
   logic [3:0]           digit_val;
   logic [1:0]           field;
   logic                 blank;
   logic [5:0]           an_nxt;
   logic [6:0]           seg_nxt;
   logic                 dp_nxt;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Scan, blink timebase and registered display outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt  <= '0;
         digit_idx <= '0;
         blink_cnt <= '0;
         blink_vis <= 1'b1;
         an_out    <= '0;
         seg_out   <= '0;
         dp_out    <= 1'b0;
      end else begin
         if (hold_cnt == HOLD_LAST) begin
            hold_cnt  <= '0;
            digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
         end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_vis <= ~blink_vis;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
         an_out  <= an_nxt;
         seg_out <= seg_nxt;
         dp_out  <= dp_nxt;
      end
   end

   always_comb begin
      digit_val = '0;
      case (digit_idx)
         3'd0:    digit_val = disp[0];
         3'd1:    digit_val = disp[1];
         3'd2:    digit_val = disp[2];
         3'd3:    digit_val = disp[3];
         3'd4:    digit_val = disp[4];
         3'd5:    digit_val = disp[5];
         default: digit_val = '0;
      endcase
      // Digit pairs map onto select codes: 0/1 -> SEC, 2/3 -> MIN, 4/5 -> HOUR
      field   = digit_idx[2:1] + 2'd1;
      blank   = !blink_vis && (select != `SELECT_NONE) && (select == field);
      an_nxt  = 6'b000001 << digit_idx;
      seg_nxt = seg_decode(digit_val);
`ifdef HOUR_ZERO_BLANK_EN
      if ((digit_idx == 3'd5) && (disp[5] == 4'd0)) seg_nxt = 7'h00;
`endif
      if (blank) seg_nxt = 7'h00;
      dp_nxt  = ((digit_idx == 3'd2) || (digit_idx == 3'd4)) && !blank;
   end

   // Binary-to-BCD converter: one subtract-by-ten per cycle per field
   assign field_done = (work < 6'd10);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if ((digit_idx == 3'd0) && (hold_cnt == '0)) state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_SEC;
         ST_SEC:    if (field_done) state_nxt = ST_MIN;
         ST_MIN:    if (field_done) state_nxt = ST_HOUR;
         ST_HOUR:   if (field_done) state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         work      <= '0;
         tens      <= '0;
         min_w     <= '0;
         hour_w    <= '0;
         stage     <= '0;
         disp      <= '0;
         frame_out <= 1'b0;
      end else begin
         frame_out <= (state == ST_COMMIT);
         case (state)
            ST_LOAD: begin
               work   <= sec_in;
               min_w  <= min_in;
               hour_w <= hour_in;
               tens   <= '0;
            end
            ST_SEC, ST_MIN, ST_HOUR: begin
               if (!field_done) begin
                  work <= work - 6'd10;
                  tens <= tens + 3'd1;
               end else begin
                  tens <= '0;
                  if (state == ST_SEC) begin
                     stage[1] <= {1'b0, tens};
                     stage[0] <= work[3:0];
                     work     <= min_w;
                  end else if (state == ST_MIN) begin
                     stage[3] <= {1'b0, tens};
                     stage[2] <= work[3:0];
                     work     <= {1'b0, hour_w};
                  end else begin
                     stage[5] <= {1'b0, tens};
                     stage[4] <= work[3:0];
                  end
               end
            end
            ST_COMMIT: disp <= stage;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/seven_seg_scan_display.md
Name: seven_seg_scan_display

Overview:
- Consumer end of the clock's time bus: takes binary sec/min/hour and the edit `select` code.
- Converts each field to two BCD digits with a sequential subtract-by-ten engine.
- Drives a 6-digit multiplexed seven-segment display, one digit at a time.
- The field being edited blinks; the block sits between the clock top level and the board display pins.

Parameters:
- CLK_FREQ_HZ, default 1000 (`KILO), input clock frequency in Hz. Must be >= 1000.
- DIGIT_HOLD_CYCLES, default 4, clock cycles each digit stays lit. Must be >= 3, so that one frame of 6*DIGIT_HOLD_CYCLES cycles is at least the 18-cycle worst-case conversion.
- BLINK_HZ, default 2, blink rate of the selected field. BLINK_HALF = CLK_FREQ_HZ/(2*BLINK_HZ) cycles per phase.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sec_in  in  6  seconds, binary, 0..63 accepted
- min_in  in  6  minutes, binary, 0..63 accepted
- hour_in  in  5  hours, binary, 0..31 accepted
- select  in  2  `SELECT_NONE / `SELECT_SEC / `SELECT_MIN / `SELECT_HOUR
- an_out  out  6  one-hot digit enable, active-high; bit0 = sec units, bit1 = sec tens, bit2 = min units, bit3 = min tens, bit4 = hour units, bit5 = hour tens
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high
- dp_out  out  1  decimal point, active-high
- frame_out  out  1  one-cycle pulse when new BCD digits are committed

Behaviour:
- Reset is synchronous: a clk edge with reset=1 sets the following.
  - an_out=0, seg_out=0, dp_out=0, frame_out=0.
  - Digit index = 0, hold counter = 0, blink counter = 0, blink phase = visible.
  - All six committed BCD digits = 0; converter in IDLE.
- Reset asserted mid-conversion aborts it; no commit, and frame_out stays 0.
- Scan:
  - The hold counter counts 0..DIGIT_HOLD_CYCLES-1. On wrap, the digit index advances 0->1->...->5->0.
  - Outputs are registered, 1 cycle after the index/counter.
  - First cycle after reset release: an_out=6'b000001.
- Converter FSM: IDLE -> LOAD -> SEC -> MIN -> HOUR -> COMMIT -> IDLE.
  - Start: leaves IDLE when digit index = 0 and hold counter = 0, including the first cycle after reset.
  - LOAD, 1 cycle: samples sec_in/min_in/hour_in into working registers. Input changes after LOAD do not affect this frame.
  - SEC/MIN/HOUR:
    - Each cycle, if work >= 10: work -= 10, tens += 1.
    - Otherwise units = work and the FSM goes to the next state. That exit takes 1 cycle.
    - Cycles per field = floor(v/10) + 1. Worst case: sec 59 = 6, min 59 = 6, hour 23 = 3.
  - COMMIT, 1 cycle: copies the six digits to the display registers and pulses frame_out for 1 cycle.
  - Out-of-range inputs are converted, not clamped: 63 gives 6,3 and 31 gives 3,1.
- Display registers change only at COMMIT, so a digit never changes while it is lit mid-frame.
- Segment encoding, standard hex:
  - 0 = 7'h3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - Codes 10..15 show seg_out=0.
- dp_out = 1 when digit 2 or digit 4 is lit; these are the min.sec and hour.min separators.
- Blink:
  - The blink counter counts 0..BLINK_HALF-1 and toggles the phase on wrap. It runs continuously, independent of select.
  - While phase = blank, the two digits of the selected field output seg_out=0 and dp_out=0. an_out still scans.
  - `SELECT_NONE: nothing blanks.
  - A change of select takes effect on the next registered output, with no counter restart.

Optional Feature:
- HOUR_ZERO_BLANK_EN: when defined, if the committed hour tens digit = 0, digit 5 shows seg_out=0 (e.g. 9:05:07 instead of 09:05:07).
- When not defined, a leading zero is shown (seg_out=7'h3F).

Test Plan:
- Reset, then release with sec=0, min=0, hour=0:
  - an_out sequence is 01,02,04,08,10,20, each held 4 cycles.
  - All seg_out = 7'h3F.
  - dp_out high on 04 and 10 only.
  - frame_out pulses once per 24-cycle frame.
- hour=23, min=59, sec=59, select=NONE: after the first COMMIT the digits are 9,5,9,5,3,2 (seg 6F,6D,6F,6D,4F,5B). Worst-case conversion completes within 18 cycles.
- Change sec_in from 12 to 34 in the middle of a frame: the displayed digits stay 2,1 until the next COMMIT, then show 4,3.
- select=`SELECT_MIN, min=45, CLK_FREQ_HZ=1000, BLINK_HZ=2:
  - Digits 2 and 3 alternate between 66/6D and 0 every 250 cycles.
  - Digits 0, 1, 4 and 5 are never blanked.
- Assert reset during the MIN state: next cycle an_out=0, seg_out=0, no frame_out pulse, and the display registers read 0.
- hour=7, with and without HOUR_ZERO_BLANK_EN: digit 5 shows 0 vs 7'h3F; digit 4 shows 07 in both builds.
